// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration stream receiver and the bitstream loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    STABLE
  } cfg_state_t;

  // Stream bit k lands at word bit k % WORD_WIDTH; the loader serialises in the same order.
  localparam bit CFG_LSB_FIRST = 1'b1;

  function automatic int cfg_words(input int total, input int width);
    return (total + width - 1) / width;
  endfunction

endpackage

// File: rtl/cfg_word_packer.sv
// Packs CFG_WIDTH-bit lanes into a word and zeroes stream bits past the payload end.
module cfg_word_packer
  import cfg_pkg::*;
#(
  parameter int CFG_WIDTH  = 1,
  parameter int WORD_WIDTH = 16,
  parameter int TOTAL_SIZE = 7055
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic                  final_cap,
  input  logic [CFG_WIDTH-1:0]  cfg_i,
  output logic                  word_full,
  output logic [WORD_WIDTH-1:0] word_out
);

  localparam int LANES     = WORD_WIDTH / CFG_WIDTH;
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TAIL_BITS = TOTAL_SIZE % WORD_WIDTH;

  logic [LANE_W-1:0]     lane_reg;
  logic [WORD_WIDTH-1:0] pack_reg;
  logic [WORD_WIDTH-1:0] word_raw;

  assign word_full = (lane_reg == LANE_W'(LANES - 1));
  assign word_out  = word_raw;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int POS = CFG_LSB_FIRST ? gi : (LANES - 1 - gi);
      logic [CFG_WIDTH-1:0] lane_bits;
      logic [CFG_WIDTH-1:0] lane_mask;

      // Only the final word can hold bits past the payload end.
      for (genvar bj = 0; bj < CFG_WIDTH; bj++) begin : g_bit
        assign lane_mask[bj] = !final_cap || (TAIL_BITS == 0) ||
                               ((gi * CFG_WIDTH + bj) < TAIL_BITS);
      end

      assign lane_bits = (capture && (lane_reg == LANE_W'(gi))) ? cfg_i
                                                                : pack_reg[POS*CFG_WIDTH +: CFG_WIDTH];
      assign word_raw[POS*CFG_WIDTH +: CFG_WIDTH] = lane_bits & lane_mask;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_reg <= '0;
      lane_reg <= '0;
    end else if (capture) begin
      if (word_full || final_cap) begin
        pack_reg <= '0;
        lane_reg <= '0;
      end else begin
        pack_reg <= word_raw;
        lane_reg <= lane_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_stream_deserializer.sv
// Serial configuration receiver: FSM, bit/word counters and the config memory write port.
module cfg_stream_deserializer
  import cfg_pkg::*;
#(
  parameter int CFG_WIDTH  = 1,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int TOTAL_SIZE = 7055
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_e,
  input  logic [CFG_WIDTH-1:0]  cfg_i,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic [31:0]           bit_count,
  output logic                  cfg_done,
  output logic                  cfg_stable,
  output logic                  cfg_err
);

  localparam int NUM_WORDS = cfg_words(TOTAL_SIZE, WORD_WIDTH);

  generate
    if (!(CFG_WIDTH == 1 || CFG_WIDTH == 2 || CFG_WIDTH == 4 ||
          CFG_WIDTH == 8 || CFG_WIDTH == 16)) begin : g_bad_cfg_width
      $fatal(1, "CFG_WIDTH must be 1, 2, 4, 8 or 16");
    end
    if ((WORD_WIDTH % CFG_WIDTH) != 0) begin : g_bad_word_width
      $fatal(1, "WORD_WIDTH must be a multiple of CFG_WIDTH");
    end
    if ((NUM_WORDS - 1) >= (1 << ADDR_WIDTH)) begin : g_bad_addr_width
      $fatal(1, "final word index does not fit in ADDR_WIDTH");
    end
  endgenerate

  cfg_state_t            state_reg, state_next;
  logic [31:0]           bit_count_reg;
  logic [31:0]           count_sum;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  wr_en_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [WORD_WIDTH-1:0] wr_data_reg;
  logic                  err_reg;
  logic                  capture;
  logic                  final_cap;
  logic                  word_full;
  logic [WORD_WIDTH-1:0] word_out;
  logic                  done_next;
  logic                  stable_next;

  assign count_sum = bit_count_reg + 32'(CFG_WIDTH);
  assign capture   = cfg_e && ((state_reg == IDLE) || (state_reg == SHIFT));
  assign final_cap = capture && (count_sum >= 32'(TOTAL_SIZE));

  cfg_word_packer #(
    .CFG_WIDTH (CFG_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .TOTAL_SIZE(TOTAL_SIZE)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .final_cap(final_cap),
    .cfg_i    (cfg_i),
    .word_full(word_full),
    .word_out (word_out)
  );

  always_comb begin
    state_next  = state_reg;
    done_next   = 1'b0;
    stable_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_e) state_next = final_cap ? DONE : SHIFT;
      end
      SHIFT: begin
        if (final_cap) state_next = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = STABLE;
      end
      STABLE: begin
        stable_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_count_reg <= '0;
      addr_reg      <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_en_reg <= capture && (word_full || final_cap);
      if (capture) begin
        bit_count_reg <= final_cap ? 32'(TOTAL_SIZE) : count_sum;
        if (word_full || final_cap) begin
          wr_addr_reg <= addr_reg;
          wr_data_reg <= word_out;
          addr_reg    <= addr_reg + 1'b1;
        end
      end
      // Enable after completion is a loader fault; the data is discarded.
      if (cfg_e && ((state_reg == DONE) || (state_reg == STABLE))) err_reg <= 1'b1;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign bit_count  = bit_count_reg;
  assign cfg_done   = done_next;
  assign cfg_stable = stable_next;
  assign cfg_err    = err_reg;

endmodule
